irq_sched: RTL and testbench

//   Interrupt scheduler for the 5-stage MIPS pipeline. Captures edges from N_SRC

---
 rtl/irq_sched_if.sv | 27 ++
 rtl/irq_sched.sv | 97 +++++++++
 tb/tb_irq_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_sched_if.sv
// rtl/irq_sched_if.sv - signal bundle between the ID stage and the interrupt scheduler
interface irq_sched_if #(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 2
);
    logic [N_SRC-1:0]   irq_src;
    logic [N_SRC-1:0]   irq_mask;
    logic               id_valid;
    logic               id_stall;
    logic               kernel_mode;
    logic               eret;
    logic               IRQ;
    logic [CAUSE_W-1:0] irq_cause;
    logic               busy;
    logic [N_SRC-1:0]   pending;
    logic               wdog_err;

    modport master (
        output irq_src, irq_mask, id_valid, id_stall, kernel_mode, eret,
        input  IRQ, irq_cause, busy, pending, wdog_err
    );

    modport slave (
        input  irq_src, irq_mask, id_valid, id_stall, kernel_mode, eret,
        output IRQ, irq_cause, busy, pending, wdog_err
    );
endinterface

// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - edge-captured, masked, priority interrupt scheduler with handler watchdog
module irq_sched #(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 2,
    parameter int WDOG_W  = 16
) (
    input  logic      clk,
    input  logic      reset,
    irq_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [N_SRC-1:0]   src_q;
    logic [N_SRC-1:0]   pending_q;
    logic [N_SRC-1:0]   edge_set;
    logic [N_SRC-1:0]   elig;
    logic [N_SRC-1:0]   clr;
    logic [CAUSE_W-1:0] sel;
    logic [CAUSE_W-1:0] cause_q;
    logic [WDOG_W-1:0]  wdog_cnt, wdog_nxt;
    logic               wdog_q;
    logic               irq;

    assign edge_set = bus.irq_src & ~src_q;
    assign elig     = pending_q & bus.irq_mask;

    // Scan downwards so the lowest eligible index wins.
    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) sel = CAUSE_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        irq       = 1'b0;
        case (state)
            IDLE: begin
                if (|elig && !bus.kernel_mode) state_nxt = ISSUE;
            end
            ISSUE: begin
                irq = bus.id_valid && !bus.id_stall && !bus.kernel_mode && |elig;
                if (irq)          state_nxt = SERVICE;
                else if (~|elig)  state_nxt = IDLE;
            end
            SERVICE: begin
                if (bus.eret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = irq && (sel == CAUSE_W'(i));
        end
    end

    always_comb begin
        wdog_nxt = wdog_cnt;
        if (state == SERVICE) begin
            if (bus.eret)              wdog_nxt = '0;
            else if (wdog_cnt != '1)   wdog_nxt = wdog_cnt + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // A new edge on a bit being serviced this cycle keeps it pending (set wins).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            pending_q <= '0;
            cause_q   <= '0;
            wdog_cnt  <= '0;
            wdog_q    <= 1'b0;
        end else begin
            src_q     <= bus.irq_src;
            pending_q <= (pending_q & ~clr) | edge_set;
            if (irq) cause_q <= sel;
            wdog_cnt  <= wdog_nxt;
            if (state == SERVICE && wdog_nxt == '1) wdog_q <= 1'b1;
        end
    end

    assign bus.IRQ       = irq;
    assign bus.irq_cause = cause_q;
    assign bus.busy      = (state == SERVICE);
    assign bus.pending   = pending_q;
    assign bus.wdog_err  = wdog_q;
endmodule

// File: tb/tb_irq_sched.sv
// tb/tb_irq_sched.sv - self-checking bench for irq_sched
module tb_irq_sched;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    irq_sched_if #(.N_SRC(4), .CAUSE_W(2)) bus ();

    irq_sched #(.N_SRC(4), .CAUSE_W(2), .WDOG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] edges;
        logic [3:0] mask;
        int         stall;
        int         exp_lat;
        logic [1:0] exp_cause;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // {IRQ, busy, wdog_err, irq_cause[1:0], pending[3:0]}
    function automatic logic [8:0] outs();
        return {bus.IRQ, bus.busy, bus.wdog_err, bus.irq_cause, bus.pending};
    endfunction

    task automatic drive_idle();
        bus.irq_src     = 4'b0;
        bus.irq_mask    = 4'hF;
        bus.id_valid    = 1'b1;
        bus.id_stall    = 1'b0;
        bus.kernel_mode = 1'b0;
        bus.eret        = 1'b0;
    endtask

    task automatic do_reset();
        step();
        drive_idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model state: what the scheduler owes the pipeline.
    logic [3:0] m_pend, m_prev;
    bit         m_armed, m_serving, m_wdog;
    int         m_cause, m_handler_cycles;

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        bit ok;
        vecs[0] = '{4'b0100, 4'b1111, 0,  2, 2'd2, 4'b0000};
        vecs[1] = '{4'b0001, 4'b1111, 3,  5, 2'd0, 4'b0000};
        vecs[2] = '{4'b1010, 4'b1111, 0,  2, 2'd1, 4'b1000};
        vecs[3] = '{4'b0110, 4'b1011, 1,  3, 2'd1, 4'b0100};
        vecs[4] = '{4'b1000, 4'b0111, 0, -1, 2'd0, 4'b1000};
        vecs[5] = '{4'b1111, 4'b1000, 0,  2, 2'd3, 4'b0111};

        drive_idle();
        #3;
        check("reset_outputs", 32'(outs()), 32'h0);
        do_reset();
        settle();
        check("post_reset_outputs", 32'(outs()), 32'h0);

        // Table: single burst of edges, optional stall, then expect pulse timing and state.
        foreach (vecs[v]) begin
            int last;
            do_reset();
            step();
            bus.irq_src  = vecs[v].edges;
            bus.irq_mask = vecs[v].mask;
            last = (vecs[v].exp_lat < 0) ? 6 : vecs[v].exp_lat;
            for (int c = 1; c <= last; c++) begin
                step();
                bus.irq_src  = 4'b0;
                bus.id_stall = (c >= 2) && (c < 2 + vecs[v].stall);
                settle();
                check($sformatf("vec%0d_irq_c%0d", v, c), 32'(bus.IRQ),
                      32'(c == vecs[v].exp_lat));
            end
            step();
            bus.id_stall = 1'b0;
            settle();
            check($sformatf("vec%0d_after", v), {29'b0, bus.busy, bus.irq_cause},
                  {29'b0, vecs[v].exp_lat >= 0, vecs[v].exp_cause});
            check($sformatf("vec%0d_pending", v), 32'(bus.pending), 32'(vecs[v].exp_pend));
        end

        // Two simultaneous edges: priority order, second issue after eret.
        do_reset();
        step(); bus.irq_src = 4'b1010;
        step(); bus.irq_src = 4'b0;
        step(); settle(); check("two_first_irq", 32'(bus.IRQ), 32'd1);
        step(); settle(); check("two_first_state", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 2'd1, 4'b1000}));
        step(); bus.eret = 1'b1;
        step(); bus.eret = 1'b0; settle();
        check("two_gap", {30'b0, bus.IRQ, bus.busy}, 32'd0);
        step(); settle(); check("two_second_irq", 32'(bus.IRQ), 32'd1);
        step(); settle(); check("two_second_state", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 2'd3, 4'b0000}));

        // Masked source keeps its request until unmasked.
        do_reset();
        step(); bus.irq_mask = 4'b1110; bus.irq_src = 4'b0001;
        ok = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(); bus.irq_src = 4'b0; settle();
            if (bus.pending[0] !== 1'b1 || bus.IRQ !== 1'b0) ok = 1'b0;
        end
        check("masked_hold", 32'(ok), 32'd1);
        step(); bus.irq_mask = 4'hF; settle();
        check("unmask_cycle", {30'b0, bus.IRQ, bus.pending[0]}, 32'd1);
        step(); settle(); check("unmask_irq", 32'(bus.IRQ), 32'd1);
        step(); settle(); check("unmask_state", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 2'd0, 4'b0000}));

        // Watchdog: trips after 15 handler cycles, sticky through eret, cleared by reset.
        do_reset();
        step(); bus.irq_src = 4'b0001;
        step(); bus.irq_src = 4'b0;
        step(); settle(); check("wdog_irq", 32'(bus.IRQ), 32'd1);
        ok = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step(); settle();
            if (bus.wdog_err !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
        end
        check("wdog_quiet", 32'(ok), 32'd1);
        step(); settle(); check("wdog_trip", {30'b0, bus.busy, bus.wdog_err}, 32'd3);
        bus.eret = 1'b1;
        step(); bus.eret = 1'b0; settle();
        check("wdog_sticky", {30'b0, bus.busy, bus.wdog_err}, 32'd1);
        reset = 1'b0; #1;
        check("wdog_reset", 32'(bus.wdog_err), 32'd0);
        step(); reset = 1'b1;

        // Reset mid-handler drops everything; only a fresh edge issues again.
        do_reset();
        step(); bus.irq_src = 4'b0001;
        step(); bus.irq_src = 4'b0;
        step();
        step(); bus.irq_src = 4'b0010;
        step(); bus.irq_src = 4'b0; settle();
        check("rst_pre", {28'b0, bus.busy, bus.pending[2:0]}, 32'b1010);
        reset = 1'b0; #1;
        check("rst_async", 32'(outs()), 32'd0);
        step(); step(); reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(); settle();
            if (bus.IRQ !== 1'b0 || bus.pending !== 4'b0) seen = 1'b1;
        end
        check("rst_quiet", 32'(seen), 32'd0);
        step(); bus.irq_src = 4'b1000;
        step(); bus.irq_src = 4'b0;
        step(); settle(); check("rst_new_irq", 32'(bus.IRQ), 32'd1);
        step(); settle(); check("rst_new_cause", 32'(bus.irq_cause), 32'd3);

        // Randomized traffic against the reference model.
        do_reset();
        m_pend = '0; m_prev = '0; m_armed = 0; m_serving = 0; m_wdog = 0;
        m_cause = 0; m_handler_cycles = 0;
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] elig, edges;
            bit         exp_irq;
            step();
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) bus.irq_src[b] = ~bus.irq_src[b];
            if ($urandom_range(15) == 0) bus.irq_mask = 4'($urandom);
            bus.id_valid    = ($urandom_range(3) != 0);
            bus.id_stall    = ($urandom_range(2) == 0);
            bus.kernel_mode = ($urandom_range(7) == 0);
            bus.eret        = ($urandom_range(3) == 0);
            settle();

            elig    = m_pend & bus.irq_mask;
            exp_irq = m_armed && bus.id_valid && !bus.id_stall && !bus.kernel_mode && (elig != 0);
            check("rand_outputs", 32'(outs()),
                  32'({exp_irq, m_serving, m_wdog, 2'(m_cause), m_pend}));

            edges = bus.irq_src & ~m_prev;
            if (m_serving) begin
                if (bus.eret) begin
                    m_serving = 0;
                    m_handler_cycles = 0;
                end else begin
                    if (m_handler_cycles < 15) m_handler_cycles++;
                    if (m_handler_cycles == 15) m_wdog = 1;
                end
            end else if (m_armed) begin
                if (exp_irq) begin
                    m_cause = lowest(elig);
                    m_pend[m_cause] = 1'b0;
                    m_armed = 0;
                    m_serving = 1;
                end else if (elig == 0) begin
                    m_armed = 0;
                end
            end else if (elig != 0 && !bus.kernel_mode) begin
                m_armed = 1;
            end
            m_pend = m_pend | edges;
            m_prev = bus.irq_src;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
